// File: rtl/ibex_wb_queue.sv
// Writeback queue: a small circular FIFO of instructions waiting to write the
// register file. At most one LOAD/STORE may be resident at a time. An LSU
// response that arrives before its entry reaches the head is parked in a
// one-entry hold register.
// Optional feature: define IBEX_WB_QUEUE_PERF_EN to store and report the
// per-instruction performance-counter retire flags.
// Type encoding of instr_type_wb_i: 0 = OTHER, 1 = LOAD, 2 = STORE.
module ibex_wb_queue #(
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       en_wb_i,
  input  logic [1:0]                 instr_type_wb_i,
  input  logic [31:0]                pc_id_i,
  input  logic                       instr_is_compressed_id_i,
  input  logic                       instr_perf_count_id_i,
  input  logic [4:0]                 rf_waddr_id_i,
  input  logic [31:0]                rf_wdata_id_i,
  input  logic                       rf_we_id_i,
  output logic                       ready_wb_o,
  output logic [$clog2(Depth+1)-1:0] occupancy_o,
  input  logic                       lsu_resp_valid_i,
  input  logic                       lsu_resp_err_i,
  input  logic [31:0]                rf_wdata_lsu_i,
  input  logic                       rf_we_lsu_i,
  output logic [4:0]                 rf_waddr_wb_o,
  output logic [31:0]                rf_wdata_wb_o,
  output logic                       rf_we_wb_o,
  input  logic [4:0]                 rf_raddr_a_i,
  input  logic [4:0]                 rf_raddr_b_i,
  output logic                       rf_hazard_a_o,
  output logic                       rf_hazard_b_o,
  output logic                       outstanding_load_wb_o,
  output logic                       outstanding_store_wb_o,
  output logic                       instr_done_wb_o,
  output logic [31:0]                pc_wb_o,
  output logic                       perf_instr_ret_wb_o,
  output logic                       perf_instr_ret_compressed_wb_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef enum logic [1:0] {
    WB_INSTR_OTHER = 2'd0,
    WB_INSTR_LOAD  = 2'd1,
    WB_INSTR_STORE = 2'd2
  } wb_instr_type_e;

  // Anything that is not LOAD or STORE behaves as OTHER.
  function automatic logic is_lsu(input logic [1:0] t);
    return (t == WB_INSTR_LOAD) || (t == WB_INSTR_STORE);
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(Depth - 1)) return '0;
    return p + 1'b1;
  endfunction

  // Control state
  logic [PtrW-1:0] head_ptr_q, tail_ptr_q;
  logic [CntW-1:0] count_q;
  logic            hold_vld_q;

  // Entry and hold payload (not reset; qualified by count/hold valid)
  logic [1:0]  type_q  [Depth];
  logic [4:0]  waddr_q [Depth];
  logic [31:0] wdata_q [Depth];
  logic        we_q    [Depth];
  logic [31:0] pc_q    [Depth];
  logic        hold_err_q, hold_we_q;
  logic [31:0] hold_data_q;

  logic [Depth-1:0] entry_vld;
  logic lsu_pending, load_present, store_present;
  logic head_valid, head_lsu, head_done, lsu_retire, enq, hold_set;
  logic resp_err, resp_we;
  logic [31:0] resp_data;
  logic [1:0]  head_type;

  assign head_type  = type_q[head_ptr_q];
  assign head_valid = (count_q != '0);
  assign head_lsu   = head_valid && is_lsu(head_type);

  // A parked response takes priority over whatever is on the live LSU port.
  assign resp_err  = hold_vld_q ? hold_err_q  : lsu_resp_err_i;
  assign resp_we   = hold_vld_q ? hold_we_q   : rf_we_lsu_i;
  assign resp_data = hold_vld_q ? hold_data_q : rf_wdata_lsu_i;

  // Retirement is suppressed during reset so a discarded entry never writes.
  assign head_done  = rst_ni && head_valid && (!head_lsu || lsu_resp_valid_i || hold_vld_q);
  assign lsu_retire = head_done && head_lsu;
  assign ready_wb_o = ((count_q < CntW'(Depth)) || head_done) &&
                      !(is_lsu(instr_type_wb_i) && lsu_pending && !lsu_retire);
  assign enq        = en_wb_i && ready_wb_o;
  assign hold_set   = lsu_resp_valid_i && lsu_pending && !head_lsu && !hold_vld_q;

  assign occupancy_o     = count_q;
  assign instr_done_wb_o = head_done;
  assign rf_waddr_wb_o   = head_valid ? waddr_q[head_ptr_q] : 5'd0;
  assign pc_wb_o         = head_valid ? pc_q[head_ptr_q] : 32'd0;
  assign outstanding_load_wb_o  = load_present;
  assign outstanding_store_wb_o = store_present;

  // Per-entry valid mask, LSU presence and read-after-write hazard detection
  always_comb begin
    int off;
    entry_vld     = '0;
    lsu_pending   = 1'b0;
    load_present  = 1'b0;
    store_present = 1'b0;
    rf_hazard_a_o = 1'b0;
    rf_hazard_b_o = 1'b0;
    for (int i = 0; i < int'(Depth); i++) begin
      off = i - int'(head_ptr_q);
      if (off < 0) off = off + int'(Depth);
      entry_vld[i] = (off < int'(count_q));
      if (entry_vld[i]) begin
        if (is_lsu(type_q[i]))          lsu_pending   = 1'b1;
        if (type_q[i] == WB_INSTR_LOAD)  load_present  = 1'b1;
        if (type_q[i] == WB_INSTR_STORE) store_present = 1'b1;
        // A head OTHER writing this cycle is already visible via forwarding.
        if ((we_q[i] || type_q[i] == WB_INSTR_LOAD) &&
            !((PtrW'(i) == head_ptr_q) && head_done && !head_lsu)) begin
          if (rf_raddr_a_i != 5'd0 && waddr_q[i] == rf_raddr_a_i) rf_hazard_a_o = 1'b1;
          if (rf_raddr_b_i != 5'd0 && waddr_q[i] == rf_raddr_b_i) rf_hazard_b_o = 1'b1;
        end
      end
    end
  end

  // Register-file write port driven by the retiring head entry
  always_comb begin
    rf_we_wb_o    = 1'b0;
    rf_wdata_wb_o = 32'd0;
    if (head_done) begin
      if (!head_lsu) begin
        rf_we_wb_o    = we_q[head_ptr_q];
        rf_wdata_wb_o = we_q[head_ptr_q] ? wdata_q[head_ptr_q] : 32'd0;
      end else if (head_type == WB_INSTR_LOAD) begin
        rf_we_wb_o    = resp_we && !resp_err;
        rf_wdata_wb_o = (resp_we && !resp_err) ? resp_data : 32'd0;
      end
    end
  end

  // Pointer, occupancy and hold-valid bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      if (enq)       tail_ptr_q <= ptr_inc(tail_ptr_q);
      if (head_done) head_ptr_q <= ptr_inc(head_ptr_q);
      if (enq && !head_done)      count_q <= count_q + 1'b1;
      else if (!enq && head_done) count_q <= count_q - 1'b1;
      if (lsu_retire)    hold_vld_q <= 1'b0;
      else if (hold_set) hold_vld_q <= 1'b1;
    end
  end

  // Entry payload capture at the tail
  always_ff @(posedge clk_i) begin
    if (enq) begin
      type_q[tail_ptr_q]  <= instr_type_wb_i;
      waddr_q[tail_ptr_q] <= rf_waddr_id_i;
      wdata_q[tail_ptr_q] <= rf_wdata_id_i;
      we_q[tail_ptr_q]    <= rf_we_id_i;
      pc_q[tail_ptr_q]    <= pc_id_i;
    end
  end

  // Early LSU response capture
  always_ff @(posedge clk_i) begin
    if (hold_set) begin
      hold_err_q  <= lsu_resp_err_i;
      hold_we_q   <= rf_we_lsu_i;
      hold_data_q <= rf_wdata_lsu_i;
    end
  end

`ifdef IBEX_WB_QUEUE_PERF_EN
  logic perf_q [Depth];
  logic comp_q [Depth];

  // Performance flags travel with each entry
  always_ff @(posedge clk_i) begin
    if (enq) begin
      perf_q[tail_ptr_q] <= instr_perf_count_id_i;
      comp_q[tail_ptr_q] <= instr_is_compressed_id_i;
    end
  end

  assign perf_instr_ret_wb_o = head_done && perf_q[head_ptr_q] && !(head_lsu && resp_err);
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o && comp_q[head_ptr_q];
`else
  logic unused_perf_inputs;
  assign unused_perf_inputs = instr_is_compressed_id_i ^ instr_perf_count_id_i;
  assign perf_instr_ret_wb_o            = 1'b0;
  assign perf_instr_ret_compressed_wb_o = 1'b0;
`endif

  // An LSU response is only meaningful while its entry is resident and unanswered
  resp_legal_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_resp_valid_i |-> (lsu_pending && !hold_vld_q));

endmodule

// File: tb/tb_ibex_wb_queue.sv
// Bench for ibex_wb_queue: directed scenarios plus randomized traffic, with a
// queue-based reference model and a writeback scoreboard.
module tb_ibex_wb_queue;

  localparam int DEPTH = 4;
  localparam logic [1:0] OTHER = 2'd0, LOAD = 2'd1, STORE = 2'd2;
`ifdef IBEX_WB_QUEUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni;
  logic en_wb_i;
  logic [1:0] instr_type_wb_i;
  logic [31:0] pc_id_i;
  logic instr_is_compressed_id_i, instr_perf_count_id_i;
  logic [4:0] rf_waddr_id_i;
  logic [31:0] rf_wdata_id_i;
  logic rf_we_id_i;
  logic ready_wb_o;
  logic [$clog2(DEPTH+1)-1:0] occupancy_o;
  logic lsu_resp_valid_i, lsu_resp_err_i, rf_we_lsu_i;
  logic [31:0] rf_wdata_lsu_i;
  logic [4:0] rf_waddr_wb_o;
  logic [31:0] rf_wdata_wb_o;
  logic rf_we_wb_o;
  logic [4:0] rf_raddr_a_i, rf_raddr_b_i;
  logic rf_hazard_a_o, rf_hazard_b_o;
  logic outstanding_load_wb_o, outstanding_store_wb_o, instr_done_wb_o;
  logic [31:0] pc_wb_o;
  logic perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o;

  ibex_wb_queue #(.Depth(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_wb_i(en_wb_i), .instr_type_wb_i(instr_type_wb_i),
    .pc_id_i(pc_id_i), .instr_is_compressed_id_i(instr_is_compressed_id_i),
    .instr_perf_count_id_i(instr_perf_count_id_i), .rf_waddr_id_i(rf_waddr_id_i),
    .rf_wdata_id_i(rf_wdata_id_i), .rf_we_id_i(rf_we_id_i), .ready_wb_o(ready_wb_o),
    .occupancy_o(occupancy_o), .lsu_resp_valid_i(lsu_resp_valid_i),
    .lsu_resp_err_i(lsu_resp_err_i), .rf_wdata_lsu_i(rf_wdata_lsu_i), .rf_we_lsu_i(rf_we_lsu_i),
    .rf_waddr_wb_o(rf_waddr_wb_o), .rf_wdata_wb_o(rf_wdata_wb_o), .rf_we_wb_o(rf_we_wb_o),
    .rf_raddr_a_i(rf_raddr_a_i), .rf_raddr_b_i(rf_raddr_b_i),
    .rf_hazard_a_o(rf_hazard_a_o), .rf_hazard_b_o(rf_hazard_b_o),
    .outstanding_load_wb_o(outstanding_load_wb_o), .outstanding_store_wb_o(outstanding_store_wb_o),
    .instr_done_wb_o(instr_done_wb_o), .pc_wb_o(pc_wb_o),
    .perf_instr_ret_wb_o(perf_instr_ret_wb_o),
    .perf_instr_ret_compressed_wb_o(perf_instr_ret_compressed_wb_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] typ; logic [4:0] waddr; logic [31:0] wdata; logic we; logic [31:0] pc;
    logic comp; logic perf; logic [31:0] rdata; logic rerr; logic rwe; bit resp_given;
  } ent_t;
  typedef struct {
    logic we; logic [4:0] waddr; logic [31:0] wdata; logic [31:0] pc; logic perf; logic perfc;
  } wb_t;

  ent_t res[$];   // instructions resident in the queue, oldest first
  wb_t  sb[$];    // expected writebacks in retire order
  bit   m_hold;   // a response has arrived for a non-head LSU entry
  bit   armed = 1'b0;
  int   total = 0, bad = 0;
  int   fixed_ra = -1;
  logic [31:0] nx_rdata; logic nx_rerr, nx_rwe;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lsu_idx();
    for (int i = 0; i < res.size(); i++) if (res[i].typ != OTHER) return i;
    return -1;
  endfunction

  // Reference model: checks control outputs, then advances one cycle
  always @(negedge clk_i) begin
    if (armed) begin
      bit hv, hlsu, done, rdy, ld, st, ha, hb;
      int k;
      hv   = res.size() > 0;
      hlsu = hv && res[0].typ != OTHER;
      done = rst_ni && hv && (!hlsu || lsu_resp_valid_i || m_hold);
      k    = lsu_idx();
      ld = 0; st = 0; ha = 0; hb = 0;
      foreach (res[i]) begin
        if (res[i].typ == LOAD)  ld = 1;
        if (res[i].typ == STORE) st = 1;
        if ((res[i].we || res[i].typ == LOAD) && !(i == 0 && done && res[i].typ == OTHER)) begin
          if (rf_raddr_a_i != 0 && res[i].waddr == rf_raddr_a_i) ha = 1;
          if (rf_raddr_b_i != 0 && res[i].waddr == rf_raddr_b_i) hb = 1;
        end
      end
      rdy = (res.size() < DEPTH || done) && !(instr_type_wb_i != OTHER && k >= 0 && !(done && hlsu));
      chk("ready", 32'(ready_wb_o), 32'(rdy));
      chk("done", 32'(instr_done_wb_o), 32'(done));
      chk("occupancy", 32'(occupancy_o), 32'(res.size()));
      chk("hazard_a", 32'(rf_hazard_a_o), 32'(ha));
      chk("hazard_b", 32'(rf_hazard_b_o), 32'(hb));
      chk("out_load", 32'(outstanding_load_wb_o), 32'(ld));
      chk("out_store", 32'(outstanding_store_wb_o), 32'(st));
      chk("pc_head", pc_wb_o, hv ? res[0].pc : 32'd0);
      chk("waddr_head", 32'(rf_waddr_wb_o), hv ? 32'(res[0].waddr) : 32'd0);
      if (!rst_ni) begin
        res.delete();
        m_hold = 0;
      end else begin
        if (lsu_resp_valid_i && k >= 0) begin
          ent_t t;
          t = res[k]; t.resp_given = 1; res[k] = t;
          if (k != 0) m_hold = 1;
        end
        if (done) begin
          if (hlsu) m_hold = 0;
          void'(res.pop_front());
        end
        if (en_wb_i && rdy) begin
          ent_t e; wb_t w;
          e = '{typ: instr_type_wb_i, waddr: rf_waddr_id_i, wdata: rf_wdata_id_i, we: rf_we_id_i,
                pc: pc_id_i, comp: instr_is_compressed_id_i, perf: instr_perf_count_id_i,
                rdata: nx_rdata, rerr: nx_rerr, rwe: nx_rwe, resp_given: 0};
          res.push_back(e);
          w.waddr = e.waddr; w.pc = e.pc;
          if (e.typ == OTHER)     w.we = e.we;
          else if (e.typ == LOAD) w.we = e.rwe && !e.rerr;
          else                    w.we = 0;
          w.wdata = !w.we ? 32'd0 : (e.typ == OTHER ? e.wdata : e.rdata);
          w.perf  = PERF && e.perf && !(e.typ != OTHER && e.rerr);
          w.perfc = w.perf && e.comp;
          sb.push_back(w);
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT retires an instruction
  always @(negedge clk_i) begin
    if (armed) begin
      if (instr_done_wb_o) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty: retire seen with no expected writeback at %0t", $time);
        end else begin
          wb_t w;
          w = sb.pop_front();
          chk("wb_we", 32'(rf_we_wb_o), 32'(w.we));
          chk("wb_waddr", 32'(rf_waddr_wb_o), 32'(w.waddr));
          chk("wb_wdata", rf_wdata_wb_o, w.wdata);
          chk("wb_pc", pc_wb_o, w.pc);
          chk("wb_perf", 32'(perf_instr_ret_wb_o), 32'(w.perf));
          chk("wb_perfc", 32'(perf_instr_ret_compressed_wb_o), 32'(w.perfc));
        end
      end else begin
        chk("idle_we", 32'(rf_we_wb_o), 32'd0);
        chk("idle_wdata", rf_wdata_wb_o, 32'd0);
        chk("idle_perf", 32'(perf_instr_ret_wb_o), 32'd0);
      end
      if (!rst_ni) sb.delete();
    end
  end

  // One clock of stimulus; rsp requests the LSU response for the resident entry
  task automatic cyc(input bit en, input logic [1:0] t, input logic [4:0] wa, input logic [31:0] wd,
                     input bit we, input bit rsp, input logic [31:0] rd, input bit re, input bit rwe);
    int k;
    @(posedge clk_i); #1;
    en_wb_i = en; instr_type_wb_i = t; rf_waddr_id_i = wa; rf_wdata_id_i = wd; rf_we_id_i = we;
    pc_id_i = $urandom; instr_is_compressed_id_i = 1'($urandom); instr_perf_count_id_i = 1'($urandom);
    nx_rdata = rd; nx_rerr = re; nx_rwe = rwe;
    rf_raddr_a_i = (fixed_ra >= 0) ? 5'(fixed_ra) : 5'($urandom_range(0, 7));
    rf_raddr_b_i = 5'($urandom_range(0, 7));
    k = lsu_idx();
    if (rsp && k >= 0 && !res[k].resp_given) begin
      lsu_resp_valid_i = 1; rf_wdata_lsu_i = res[k].rdata;
      lsu_resp_err_i = res[k].rerr; rf_we_lsu_i = res[k].rwe;
    end else begin
      lsu_resp_valid_i = 0; rf_wdata_lsu_i = $urandom;
      lsu_resp_err_i = 1'($urandom); rf_we_lsu_i = 1'($urandom);
    end
  endtask

  task automatic idle(input bit rsp);
    cyc(0, OTHER, 0, 0, 0, rsp, 0, 0, 0);
  endtask

  task automatic reset_cycle();
    @(posedge clk_i); #1;
    rst_ni = 0; en_wb_i = 0; lsu_resp_valid_i = 0;
    @(posedge clk_i); #1;
    rst_ni = 1;
  endtask

  initial begin
    rst_ni = 0; en_wb_i = 0; instr_type_wb_i = OTHER; pc_id_i = 0;
    instr_is_compressed_id_i = 0; instr_perf_count_id_i = 0; rf_waddr_id_i = 0;
    rf_wdata_id_i = 0; rf_we_id_i = 0; lsu_resp_valid_i = 0; lsu_resp_err_i = 0;
    rf_wdata_lsu_i = 0; rf_we_lsu_i = 0; rf_raddr_a_i = 0; rf_raddr_b_i = 0;
    nx_rdata = 0; nx_rerr = 0; nx_rwe = 0; m_hold = 0;
    repeat (2) @(posedge clk_i);
    armed = 1;
    #1 rst_ni = 1;

    // Back-to-back OTHER stream: one write per cycle, queue never fills
    repeat (5) cyc(1, OTHER, 3, 32'hA5, 1, 0, 0, 0, 0);
    idle(0);

    // OTHER blocked behind LOAD; hazard on the load destination until it retires
    fixed_ra = 5;
    cyc(1, LOAD, 5, 0, 1, 0, 32'hDEAD, 0, 1);
    cyc(1, OTHER, 6, 32'h66, 1, 0, 0, 0, 0);
    idle(0); idle(0);
    idle(1); idle(0); idle(0);
    fixed_ra = -1;

    // Early response parked while an OTHER is head, retired from the hold next cycle
    cyc(1, LOAD, 7, 0, 1, 0, 32'h1111, 0, 1);
    cyc(1, OTHER, 2, 32'h22, 1, 0, 0, 0, 0);
    idle(0);
    cyc(1, LOAD, 4, 0, 1, 1, 32'h4444, 0, 1);
    idle(1); idle(0); idle(0);

    // Load with error: no write, still done
    cyc(1, LOAD, 9, 0, 1, 0, 32'hBAD, 1, 1);
    idle(1); idle(0);

    // Second LSU op refused while a load is pending, accepted as the load retires
    cyc(1, LOAD, 1, 0, 1, 0, 32'h5A5A, 0, 1);
    cyc(1, OTHER, 2, 32'h2, 1, 0, 0, 0, 0);
    cyc(1, OTHER, 3, 32'h3, 1, 0, 0, 0, 0);
    repeat (3) cyc(1, STORE, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, STORE, 0, 0, 0, 1, 0, 0, 0);
    idle(0); idle(0);
    cyc(1, OTHER, 8, 32'h8, 1, 0, 0, 0, 0);
    cyc(1, OTHER, 10, 32'hA, 1, 0, 0, 0, 0);
    idle(0);
    reset_cycle();
    idle(0); idle(0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) reset_cycle();
      else cyc(($urandom % 4) != 0, 2'($urandom % 3), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom), ($urandom % 3) == 0, $urandom, ($urandom % 4) == 0, 1'($urandom));
    end
    repeat (20) idle(1);
    @(negedge clk_i);
    chk("drained_model", 32'(res.size()), 32'd0);
    chk("drained_sb", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
